// File: rtl/skid_buf_pkg.sv
// Shared types and defaults for the skid_buf register slice.
package skid_buf_pkg;

    // Occupancy of the slice: main register M and skid register S.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // M empty, S empty
        BUSY  = 2'd1,   // M full,  S empty
        FULL  = 2'd2    // M full,  S full
    } skid_state_e;

    localparam int SKID_DW_DEF = 32;
    localparam int SKID_CW_DEF = 16;

    // Downstream sees a beat whenever M holds one.
    function automatic logic state_has_data(input skid_state_e s);
        return (s != EMPTY);
    endfunction

    // Upstream may push unless both registers are occupied.
    function automatic logic state_can_accept(input skid_state_e s);
        return (s != FULL);
    endfunction

endpackage

// File: rtl/skid_buf_dffen.sv
// Load-enabled data register without reset, used for the slice payload.
module dffen
    import skid_buf_pkg::*;
#(
    parameter int W = SKID_DW_DEF
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d only on enabled edges; payload needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice (skid buffer).
// in_ready and out_valid come straight from flops, out_data straight from M.
// Optional: define SKID_BUF_STALL_CNT_EN to add the saturating stall_cnt port.
module skid_buf
    import skid_buf_pkg::*;
#(
    parameter int DW = SKID_DW_DEF,
    parameter int CW = SKID_CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef SKID_BUF_STALL_CNT_EN
    ,
    output logic [CW-1:0] stall_cnt
`endif
);

    generate
        if (DW < 1 || CW < 1) begin : g_bad_param
            $error("skid_buf: DW and CW must be at least 1");
        end
    endgenerate

    skid_state_e   state_q, state_d;
    logic          in_ready_q, out_valid_q;
    logic          in_fire, out_fire;
    logic          m_en, s_en;
    logic [DW-1:0] m_d, s_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state and register load enables; flush discards any fire this cycle.
    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        s_en    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        m_en    = 1'b1;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        m_en = 1'b1;
                    end else if (in_fire) begin
                        s_en    = 1'b1;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        m_en    = 1'b1;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // M refills from S when draining FULL, otherwise straight from upstream.
    assign m_d = (state_q == FULL) ? s_q : in_data;

    // State and registered handshake flags; in_ready stays low until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= state_has_data(state_d);
            in_ready_q  <= state_can_accept(state_d);
        end
    end

    dffen #(.W(DW)) u_main (
        .clk (clk),
        .en  (m_en),
        .d   (m_d),
        .q   (out_data)
    );

    dffen #(.W(DW)) u_skid (
        .clk (clk),
        .en  (s_en),
        .d   (in_data),
        .q   (s_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

`ifdef SKID_BUF_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    // Count cycles where upstream offers a beat we cannot take; survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (in_valid && !in_ready_q) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/skid_buf.md
# skid_buf

Two-entry valid/ready register slice that breaks the combinational `ready` path between two pipeline stages while sustaining one transfer per cycle. It sits directly upstream of the `dffen`-based datapath registers. It turns an upstream valid/ready stream into registered, stall-safe data, and its handshake generates the load enables for its own data registers. Ordering is strictly preserved and no beat is dropped or duplicated, except on `flush`.

## Interface
- `DW`, 32, payload width in bits
- `CW`, 16, stall-counter width (used only when the counter is compiled in)

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear of buffered contents
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  slice can accept; driven directly from a flop
- `in_data`  in  DW  upstream payload
- `out_valid`  out  1  downstream beat valid; driven directly from a flop
- `out_ready`  in  1  downstream accepts
- `out_data`  out  DW  downstream payload; driven directly from the main register
- `stall_cnt`  out  CW  saturating upstream-stall count; present only with the macro defined

## Operation
- Transfer rules:
  - In-fire = `in_valid & in_ready`.
  - Out-fire = `out_valid & out_ready`.
- Storage:
  - Main register M drives `out_data`.
  - Skid register S holds an overflow beat.
  - Data registers have no reset.
- States:
  - EMPTY: M empty, S empty.
  - BUSY: M full, S empty.
  - FULL: M full, S full.
- Port flags by state:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL) once out of reset.
- Transitions, with `flush` = 0:
  - EMPTY, in-fire: M <= in_data, go to BUSY.
  - BUSY, in-fire and out-fire: M <= in_data, stay in BUSY.
  - BUSY, in-fire only: S <= in_data, go to FULL.
  - BUSY, out-fire only: go to EMPTY.
  - FULL, out-fire: M <= S, go to BUSY. In-fire cannot occur in FULL.
  - Any state, no fire: hold state and data.
- Flush:
  - `flush` = 1 has highest priority: next state is EMPTY and `in_ready` = 1.
  - Any in-fire or out-fire in the flush cycle is discarded; the upstream beat is lost by design.
  - M and S contents are left unchanged.
- Protocol obligations:
  - Upstream must hold `in_valid`/`in_data` stable while `in_valid & !in_ready`.
  - The slice guarantees `out_valid`/`out_data` stay stable while `out_valid & !out_ready`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State is EMPTY.
  - `out_valid` = 0.
  - `in_ready` = 0.
  - `stall_cnt` = 0.
  - `out_data` is undefined until the first load.
- Reset release: `in_ready` rises on the first `clk` rising edge after `rst_n` deasserts.
- Reset asserted mid-operation: all buffered beats are dropped immediately, with no partial transfer.
- Latency: a beat accepted at edge k is visible on `out_data` with `out_valid` = 1 after edge k; minimum one cycle.
- Throughput: one beat per cycle with `out_ready` held at 1.
- Back-pressure response:
  - `in_ready` falls on the edge after the first stalled in-fire (BUSY to FULL).
  - Exactly one extra beat is absorbed by S.
- Recovery: from FULL, one out-fire makes `in_ready` = 1 on the next cycle.
- Timing isolation: no combinational path from any input to any output.

## Configuration
- Macro `SKID_BUF_STALL_CNT_EN`.
- Defined:
  - Adds the `stall_cnt` port and a CW-bit counter.
  - The counter increments every cycle with `in_valid & !in_ready` while out of reset.
  - It saturates at 2^CW-1 and does not wrap.
  - `flush` does not clear it; only `rst_n` does.
- Undefined: no port, no counter, no extra logic.

## Structure
- Package `skid_buf_pkg`:
  - State enum `skid_state_e` (EMPTY, BUSY, FULL), 2-bit encoding.
  - Default widths `SKID_DW_DEF` = 32 and `SKID_CW_DEF` = 16.
- Sub-module: instantiate `dffen` twice, for M and S.
  - M enable: EMPTY & in-fire, or BUSY & in-fire & out-fire, or FULL & out-fire.
  - S enable: BUSY & in-fire & !out-fire.
  - The enable logic and state flop live in `skid_buf`.

## Test plan
- Reset then stream: after `rst_n` release, drive `in_valid` = 1 with data 0x1,0x2,0x3 and `out_ready` = 1. Expect `in_ready` = 1 from edge 1, and `out_data` 0x1,0x2,0x3 on consecutive cycles, each one cycle after acceptance.
- Back-pressure:
  - Stimulus: stream 0xA,0xB,0xC,0xD and drop `out_ready` while 0xA is on the output.
  - Expect 0xB absorbed into S, `in_ready` = 0, and 0xC held upstream.
  - Then raise `out_ready`: expect output order 0xA,0xB,0xC,0xD with no gaps after the first release cycle.
- Flush in FULL: with two beats held and `in_valid` = 1, pulse `flush` for one cycle. Expect `out_valid` = 0 and `in_ready` = 1 next cycle, and the upstream beat offered in the flush cycle absent from the output.
- Async reset mid-transfer: assert `rst_n` = 0 between edges while in FULL. Expect `out_valid` and `in_ready` = 0 immediately, without waiting for `clk`.
- Random valid/ready (10k beats): scoreboard confirms in-order, lossless delivery and stable `out_data` during stalls.
- With `SKID_BUF_STALL_CNT_EN` and CW = 4: hold `out_ready` = 0 and `in_valid` = 1 for 20 cycles. Expect `stall_cnt` to count up and stick at 15.
